// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame receiver.
package pixel_pkg;

  localparam int unsigned PIXEL_W     = 8;
  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_SHORT   = 0;
  localparam int unsigned ERR_LONG    = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  // Ceiling log2, never below 1 so derived vectors stay legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pixel_frame_buf.sv
// N x 8 frame buffer: one synchronous write port, one synchronous read port.
module pixel_frame_buf
  import pixel_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  logic [PIXEL_W-1:0] mem [N];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Addresses past the frame read back as zero.
  if (N == (1 << AW)) begin : g_full
    always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
    end
  end else begin : g_part
    always_ff @(posedge clk) begin
      if (rst)                      rd_data <= '0;
      else if (32'(rd_addr) < N)    rd_data <= mem[rd_addr];
      else                          rd_data <= '0;
    end
  end

endmodule

// File: rtl/pixel_frame_rx.sv
// Captures one AXIS pixel frame into a buffer with min/max/sum statistics.
module pixel_frame_rx
  import pixel_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLUMNS = 4,
  parameter int unsigned TIMEOUT = 1023,
  localparam int unsigned N  = ROWS * COLUMNS,
  localparam int unsigned AW = clog2(N),
  localparam int unsigned SW = PIXEL_W + AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_req,
  output logic               trigger,
  input  logic               valid,
  output logic               ready,
  input  logic               tlast,
  input  logic [PIXEL_W-1:0] tdata,
  output logic               frame_valid,
  output logic               frame_done,
  input  logic               frame_ack,
  output logic [ERR_W-1:0]   err,
  output logic [PIXEL_W-1:0] pix_min,
  output logic [PIXEL_W-1:0] pix_max,
  output logic [SW-1:0]      pix_sum,
  input  logic [AW-1:0]      rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  localparam int unsigned TW = clog2(TIMEOUT + 1);

  state_t             state, state_d;
  logic [AW-1:0]      wr_ptr, wr_ptr_d;
  logic [TW-1:0]      idle_cnt, idle_d;
  logic               ready_d, trigger_d, frame_valid_d, frame_done_d;
  logic [ERR_W-1:0]   err_d;
  logic [PIXEL_W-1:0] pix_min_d, pix_max_d;
  logic [SW-1:0]      pix_sum_d;
  logic               beat_c, we_c, timeout_c;

  assign beat_c    = valid && ready;
  assign we_c      = beat_c && (state == ST_RECV);
  assign timeout_c = (idle_cnt == TW'(TIMEOUT - 1));

  pixel_frame_buf #(.N(N), .AW(AW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (we_c),
    .wr_addr (wr_ptr),
    .wr_data (tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      idle_cnt    <= '0;
      ready       <= 1'b0;
      trigger     <= 1'b0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= '0;
      pix_min     <= '1;
      pix_max     <= '0;
      pix_sum     <= '0;
    end else begin
      state       <= state_d;
      wr_ptr      <= wr_ptr_d;
      idle_cnt    <= idle_d;
      ready       <= ready_d;
      trigger     <= trigger_d;
      frame_valid <= frame_valid_d;
      frame_done  <= frame_done_d;
      err         <= err_d;
      pix_min     <= pix_min_d;
      pix_max     <= pix_max_d;
      pix_sum     <= pix_sum_d;
    end
  end

  always_comb begin
    state_d   = state;
    wr_ptr_d  = wr_ptr;
    idle_d    = idle_cnt;
    trigger_d = 1'b0;
    err_d     = err;
    pix_min_d = pix_min;
    pix_max_d = pix_max;
    pix_sum_d = pix_sum;

    case (state)
      ST_IDLE: begin
        if (capture_req) begin
          state_d   = ST_RECV;
          trigger_d = 1'b1;
          wr_ptr_d  = '0;
          idle_d    = '0;
          pix_min_d = '1;
          pix_max_d = '0;
          pix_sum_d = '0;
          err_d     = '0;
        end
      end
      ST_RECV: begin
        if (beat_c) begin
          idle_d    = '0;
          wr_ptr_d  = wr_ptr + 1'b1;
          pix_min_d = (tdata < pix_min) ? tdata : pix_min;
          pix_max_d = (tdata > pix_max) ? tdata : pix_max;
          pix_sum_d = pix_sum + SW'(tdata);
          if (tlast) begin
            state_d = ST_HOLD;
            if (wr_ptr != AW'(N - 1)) err_d[ERR_SHORT] = 1'b1;
          end else if (wr_ptr == AW'(N - 1)) begin
            state_d          = ST_DRAIN;
            err_d[ERR_LONG]  = 1'b1;
          end
        end else if (timeout_c) begin
          state_d            = ST_HOLD;
          err_d[ERR_TIMEOUT] = 1'b1;
        end else begin
          idle_d = idle_cnt + 1'b1;
        end
      end
      // Surplus beats are swallowed until tlast; statistics stay frozen.
      ST_DRAIN: begin
        if (beat_c) begin
          idle_d = '0;
          if (tlast) state_d = ST_HOLD;
        end else if (timeout_c) begin
          state_d            = ST_HOLD;
          err_d[ERR_TIMEOUT] = 1'b1;
        end else begin
          idle_d = idle_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (frame_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d       = (state_d == ST_RECV) || (state_d == ST_DRAIN);
    frame_valid_d = (state_d == ST_HOLD);
    frame_done_d  = (state_d == ST_HOLD) && (state != ST_HOLD);
  end

endmodule

// File: tb/tb_pixel_frame_rx.sv
// Directed self-checking bench for pixel_frame_rx (TIMEOUT shortened to 8).
module tb_pixel_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_req = 1'b0;
  logic        valid = 1'b0;
  logic        tlast = 1'b0;
  logic        frame_ack = 1'b0;
  logic [7:0]  tdata = 8'h00;
  logic [3:0]  rd_addr = 4'h0;
  logic        trigger, ready, frame_valid, frame_done;
  logic [2:0]  err;
  logic [7:0]  pix_min, pix_max, rd_data;
  logic [11:0] pix_sum;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int trig_cnt = 0;

  pixel_frame_rx #(.ROWS(4), .COLUMNS(4), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .capture_req (capture_req),
    .trigger     (trigger),
    .valid       (valid),
    .ready       (ready),
    .tlast       (tlast),
    .tdata       (tdata),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .frame_ack   (frame_ack),
    .err         (err),
    .pix_min     (pix_min),
    .pix_max     (pix_max),
    .pix_sum     (pix_sum),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (trigger) trig_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    valid = 1'b1; tdata = d; tlast = last;
    step();
    valid = 1'b0; tlast = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0h exp 0", ready); end
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got %0h exp 0", trigger); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %0h exp 0", frame_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0h exp 0", frame_done); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err got %0h exp 0", err); end
    checks++; if (pix_min !== 8'hFF) begin errors++; $display("FAIL reset_min got %0h exp ff", pix_min); end
    checks++; if (pix_max !== 8'h00) begin errors++; $display("FAIL reset_max got %0h exp 0", pix_max); end
    checks++; if (pix_sum !== 12'h000) begin errors++; $display("FAIL reset_sum got %0h exp 0", pix_sum); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", rd_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full();
    int d0, t0;
    d0 = done_cnt; t0 = trig_cnt;
    capture_req = 1'b1; step(); capture_req = 1'b0;
    checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL full_trigger got %0h exp 1", trigger); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_ready got %0h exp 1", ready); end
    for (int i = 0; i < 16; i++) begin
      beat(8'(i), i == 15);
      if (i == 0) begin
        checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL full_trigger_drop got %0h exp 0", trigger); end
      end
    end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL full_frame_valid got %0h exp 1", frame_valid); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL full_frame_done got %0h exp 1", frame_done); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_ready_hold got %0h exp 0", ready); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL full_err got %0h exp 0", err); end
    checks++; if (pix_min !== 8'h00) begin errors++; $display("FAIL full_min got %0h exp 0", pix_min); end
    checks++; if (pix_max !== 8'h0F) begin errors++; $display("FAIL full_max got %0h exp f", pix_max); end
    checks++; if (pix_sum !== 12'd120) begin errors++; $display("FAIL full_sum got %0d exp 120", pix_sum); end
    rd_addr = 4'd5;
    step();
    checks++; if (rd_data !== 8'h05) begin errors++; $display("FAIL full_rd_data got %0h exp 5", rd_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL full_done_pulse got %0h exp 0", frame_done); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_count got %0d exp 1", done_cnt - d0); end
    checks++; if (trig_cnt - t0 !== 1) begin errors++; $display("FAIL full_trig_count got %0d exp 1", trig_cnt - t0); end
    ack();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL full_ack_valid got %0h exp 0", frame_valid); end
  endtask

  task automatic test_short();
    capture_req = 1'b1; step(); capture_req = 1'b0;
    for (int i = 0; i < 10; i++) beat(8'h20, i == 9);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL short_frame_valid got %0h exp 1", frame_valid); end
    checks++; if (err !== 3'b001) begin errors++; $display("FAIL short_err got %0h exp 1", err); end
    checks++; if (pix_sum !== 12'd320) begin errors++; $display("FAIL short_sum got %0d exp 320", pix_sum); end
    checks++; if (pix_min !== 8'h20) begin errors++; $display("FAIL short_min got %0h exp 20", pix_min); end
    checks++; if (pix_max !== 8'h20) begin errors++; $display("FAIL short_max got %0h exp 20", pix_max); end
    rd_addr = 4'd9;
    step();
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL short_rd_data got %0h exp 20", rd_data); end
    ack();
  endtask

  task automatic test_long();
    int miss;
    miss = 0;
    capture_req = 1'b1; step(); capture_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready !== 1'b1) miss++;
      beat(8'h01, i == 19);
      if (i == 15) begin
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL long_drain_valid got %0h exp 0", frame_valid); end
      end
    end
    checks++; if (miss !== 0) begin errors++; $display("FAIL long_ready_missing got %0d exp 0", miss); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL long_frame_valid got %0h exp 1", frame_valid); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL long_ready_hold got %0h exp 0", ready); end
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL long_err got %0h exp 2", err); end
    checks++; if (pix_sum !== 12'd16) begin errors++; $display("FAIL long_sum got %0d exp 16", pix_sum); end
    checks++; if (pix_max !== 8'h01) begin errors++; $display("FAIL long_max got %0h exp 1", pix_max); end
    ack();
  endtask

  task automatic test_timeout();
    capture_req = 1'b1; step(); capture_req = 1'b0;
    for (int i = 0; i < 3; i++) beat(8'h05, 1'b0);
    for (int i = 0; i < 7; i++) step();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL timeout_early_valid got %0h exp 0", frame_valid); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL timeout_early_ready got %0h exp 1", ready); end
    step();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL timeout_frame_valid got %0h exp 1", frame_valid); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL timeout_frame_done got %0h exp 1", frame_done); end
    checks++; if (err !== 3'b100) begin errors++; $display("FAIL timeout_err got %0h exp 4", err); end
    checks++; if (pix_sum !== 12'd15) begin errors++; $display("FAIL timeout_sum got %0d exp 15", pix_sum); end
    checks++; if (pix_min !== 8'h05) begin errors++; $display("FAIL timeout_min got %0h exp 5", pix_min); end
    ack();
  endtask

  task automatic test_toggle();
    int t0;
    capture_req = 1'b1; step(); capture_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      beat(8'(i), i == 15);
      if (i < 15) begin
        tdata = 8'hAA; tlast = 1'b1;
        step();
        tlast = 1'b0;
      end
    end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL toggle_frame_valid got %0h exp 1", frame_valid); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL toggle_err got %0h exp 0", err); end
    checks++; if (pix_sum !== 12'd120) begin errors++; $display("FAIL toggle_sum got %0d exp 120", pix_sum); end
    checks++; if (pix_max !== 8'h0F) begin errors++; $display("FAIL toggle_max got %0h exp f", pix_max); end
    checks++; if (pix_min !== 8'h00) begin errors++; $display("FAIL toggle_min got %0h exp 0", pix_min); end
    t0 = trig_cnt;
    frame_ack = 1'b1; capture_req = 1'b1;
    step();
    frame_ack = 1'b0; capture_req = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL toggle_ack_valid got %0h exp 0", frame_valid); end
    step();
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL toggle_ack_trigger got %0h exp 0", trigger); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL toggle_ack_ready got %0h exp 0", ready); end
    step();
    checks++; if (trig_cnt !== t0) begin errors++; $display("FAIL toggle_trig_count got %0d exp %0d", trig_cnt, t0); end
  endtask

  task automatic test_rst_mid();
    int d0;
    d0 = done_cnt;
    capture_req = 1'b1; step(); capture_req = 1'b0;
    for (int i = 0; i < 7; i++) beat(8'(64 + i), 1'b0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ready got %0h exp 1", ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %0h exp 0", ready); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_frame_valid got %0h exp 0", frame_valid); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL rstmid_err got %0h exp 0", err); end
    checks++; if (pix_sum !== 12'd0) begin errors++; $display("FAIL rstmid_sum got %0d exp 0", pix_sum); end
    rd_addr = 4'd3;
    step();
    checks++; if (rd_data !== 8'h43) begin errors++; $display("FAIL rstmid_buf_kept got %0h exp 43", rd_data); end
    step();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rstmid_no_done got %0d exp %0d", done_cnt, d0); end
    capture_req = 1'b1; step(); capture_req = 1'b0;
    for (int i = 0; i < 16; i++) beat(8'(3 * i), i == 15);
    step();
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL rstmid_next_err got %0h exp 0", err); end
    checks++; if (pix_sum !== 12'd360) begin errors++; $display("FAIL rstmid_next_sum got %0d exp 360", pix_sum); end
    checks++; if (pix_max !== 8'd45) begin errors++; $display("FAIL rstmid_next_max got %0d exp 45", pix_max); end
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL rstmid_next_done got %0d exp %0d", done_cnt, d0 + 1); end
    ack();
  endtask

  initial begin
    test_reset();
    test_full();
    test_short();
    test_long();
    test_timeout();
    test_toggle();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_frame_rx.md
PIXEL_FRAME_RX -- requirements
Module: pixel_frame_rx

Interface
REQ-001 ROWS, 4, pixel rows per frame.
REQ-002 COLUMNS, 4, pixel columns per frame.
REQ-003 TIMEOUT, 1023, consecutive beat-less cycles tolerated in RECV/DRAIN.
REQ-004 Derived localparams SHALL be N=ROWS*COLUMNS, AW=clog2(N), SW=8+AW.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  one clock; reset is synchronous and active-high.
REQ-007 capture_req  in  1  request a new frame capture.
REQ-008 trigger  out  1  one-cycle photo trigger to the pixel-array controller.
REQ-009 valid  in  1  AXIS tvalid from the pixel source.
REQ-010 ready  out  1  AXIS tready to the pixel source.
REQ-011 tlast  in  1  AXIS end-of-frame marker.
REQ-012 tdata  in  8  AXIS pixel value, binary unsigned.
REQ-013 frame_valid  out  1  frame buffer and statistics complete and stable.
REQ-014 frame_done  out  1  one-cycle pulse on frame completion.
REQ-015 frame_ack  in  1  consumer releases the held frame.
REQ-016 err  out  3  bit0 short frame, bit1 long frame, bit2 timeout.
REQ-017 pix_min / pix_max  out  8 each  minimum / maximum stored pixel.
REQ-018 pix_sum  out  SW  sum of stored pixels.
REQ-019 rd_addr  in  AW  frame buffer read address.
REQ-020 rd_data  out  8  frame buffer read data.

Function
REQ-021 States SHALL be IDLE, RECV, DRAIN, HOLD; beat = valid && ready; tdata/tlast ignored without a beat.
REQ-022 ready SHALL be a registered function of state (1 in RECV/DRAIN, else 0); no combinational valid->ready path.
REQ-023 IDLE: capture_req=1 -> trigger=1 for exactly the next cycle, wr_ptr=0, idle counter=0, pix_min=FF, pix_max=00, pix_sum=0, err=000, next state RECV.
REQ-024 RECV: each beat writes tdata to buf[wr_ptr], increments wr_ptr, updates min/max/sum on the same edge, clears idle counter.
REQ-025 RECV beat with tlast at wr_ptr==N-1 -> HOLD, err unchanged (000).
REQ-026 RECV beat with tlast at wr_ptr<N-1 -> pixel stored and counted, HOLD, err[0]=1.
REQ-027 RECV beat without tlast at wr_ptr==N-1 -> pixel stored and counted, DRAIN, err[1]=1.
REQ-028 DRAIN: beats accepted and discarded, statistics frozen; beat with tlast -> HOLD.
REQ-029 RECV/DRAIN with no beat for TIMEOUT consecutive cycles -> HOLD, err[2]=1.
REQ-030 frame_done SHALL pulse for one cycle, coincident with the first HOLD cycle; frame_valid=1 throughout HOLD.
REQ-031 HOLD: buffer, err, statistics stable; frame_ack -> IDLE next cycle, frame_valid drops; capture_req ignored in HOLD, including the ack cycle.
REQ-032 rd_data SHALL equal buf[rd_addr] one cycle after rd_addr is presented, in any state; rd_addr>=N returns 0.
REQ-033 pix_sum width SW SHALL never overflow (N x 255); min/max compare unsigned.

Reset
REQ-034 rst SHALL set state=IDLE, ready=0, trigger=0, frame_valid=0, frame_done=0, err=000, pix_min=FF, pix_max=00, pix_sum=0, rd_data=0, wr_ptr and idle counter 0.
REQ-035 Buffer contents SHALL NOT be cleared by rst.
REQ-036 rst mid-frame SHALL abandon the frame without a frame_done pulse.

Structure
REQ-037 pixel_pkg SHALL hold the state enum, PIXEL_W=8, the clog2 function and err bit-index constants.
REQ-038 Sub-module pixel_frame_buf SHALL implement the N x 8 buffer: one synchronous write port, one synchronous read port.

Verification
REQ-039 Defaults; capture_req; 16 beats 0..15, tlast on 16th -> trigger 1 cycle, one frame_done, err=000, min=0, max=15, sum=120; rd_addr=5 -> rd_data=5 next cycle.
REQ-040 Short: 10 beats of 8'h20, tlast on 10th -> HOLD, err=001, sum=320, min=max=8'h20.
REQ-041 Long: 20 beats of 8'h01, tlast on 20th -> err=010, sum=16, ready=1 for all 20 beats, HOLD after 20th.
REQ-042 Timeout: TIMEOUT=8; 3 beats of 8'h05 then valid=0 for 8 cycles -> err=100, frame_valid=1, sum=15.
REQ-043 valid toggled every other cycle over a full 16-beat frame -> same result as REQ-039; frame_ack+capture_req same cycle in HOLD -> IDLE, no trigger.
REQ-044 rst after beat 7 -> IDLE next cycle, ready=0, err=000, no frame_done; next capture completes normally.
